// File: rtl/fsk_tx_framer_if.sv
// SPI-word-in / FSK-bit-out bus of the FSK transmit framer.
// master: the SPI controller side (drives rx_ready/rx_data) plus the control inputs.
// slave:  the framer itself.
interface fsk_tx_framer_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              rx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              enable;
   logic              clr_ovf;
   logic              fsk_bit;
   logic              bit_strobe;
   logic              tx_active;
   logic [LVL_W-1:0]  fifo_level;
   logic              overflow;

   modport master (
      output rx_ready, rx_data, enable, clr_ovf,
      input  fsk_bit, bit_strobe, tx_active, fifo_level, overflow
   );

   modport slave (
      input  rx_ready, rx_data, enable, clr_ovf,
      output fsk_bit, bit_strobe, tx_active, fifo_level, overflow
   );
endinterface

// File: rtl/fsk_tx_framer.sv
// FSK transmit framer: captures SPI words on the rising edge of rx_ready, queues them
// in a FIFO and serialises them MSB-first at clk/BAUD_DIV onto the modulator's
// mark/space select (fsk_bit=1 = mark, also the idle level).
// Optional build macro: FSK_PREAMBLE_EN adds PREAMBLE_LEN x PREAMBLE_WORD in front of
// every burst that starts from IDLE.
//
// state   | meaning
// S_IDLE  | line idle (fsk_bit=1), waiting for enable with a non-empty FIFO
// S_PRE   | sending preamble words (FSK_PREAMBLE_EN builds only)
// S_SHIFT | sending a data word; chains straight into the next one when possible
module fsk_tx_framer #(
   parameter int          DATA_W        = 8,
   parameter int          FIFO_DEPTH    = 16,
   parameter int          BAUD_DIV      = 16,
   parameter int          PREAMBLE_LEN  = 2,
   parameter int unsigned PREAMBLE_WORD = 'hAA
) (
   input logic          clk,
   input logic          rst,
   fsk_tx_framer_if.slave fsk_bus
);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = AW + 1;
   localparam int BIT_W  = $clog2(DATA_W);
   localparam int BAUD_W = $clog2(BAUD_DIV);
`ifdef FSK_PREAMBLE_EN
   localparam int PRE_W  = $clog2(PREAMBLE_LEN + 1);
`endif

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (BAUD_DIV < 2 || DATA_W < 2) begin : g_bad_timing
      $error("BAUD_DIV and DATA_W must be at least 2");
   end
   if (PREAMBLE_LEN < 1 || (PREAMBLE_WORD >> DATA_W) != 0) begin : g_bad_preamble
      $error("PREAMBLE_LEN must be >= 1 and PREAMBLE_WORD must fit in DATA_W bits");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
`ifdef FSK_PREAMBLE_EN
      ,S_PRE  = 2'd2
`endif
   } state_t;

   state_t              r_state, w_state_nxt;
   logic                r_rx_q;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0]    r_level;
   logic                r_overflow;
   logic [DATA_W-1:0]   r_shreg, w_shreg_nxt;
   logic [BIT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
   logic [BAUD_W-1:0]   r_baud_cnt, w_baud_cnt_nxt;
`ifdef FSK_PREAMBLE_EN
   logic [PRE_W-1:0]    r_pre_cnt, w_pre_cnt_nxt;
`endif

   logic                w_push, w_push_ok, w_drop, w_pop, w_full, w_have, w_bit_end;
   logic [DATA_W-1:0]   w_rd_data;

   // A word is offered once per rx_ready high period; a pop in the same cycle frees a full slot.
   assign w_push    = fsk_bus.rx_ready & ~r_rx_q;
   assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_drop    = w_push & ~w_push_ok;
   assign w_rd_data = r_mem[r_rd_ptr];
   assign w_have    = fsk_bus.enable & (r_level != '0);
   assign w_bit_end = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));

   assign fsk_bus.fsk_bit    = (r_state == S_IDLE) ? 1'b1 : r_shreg[DATA_W-1];
   assign fsk_bus.tx_active  = (r_state != S_IDLE);
   assign fsk_bus.bit_strobe = (r_state != S_IDLE) && (r_baud_cnt == '0);
   assign fsk_bus.fifo_level = r_level;
   assign fsk_bus.overflow   = r_overflow;

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= fsk_bus.rx_data;
   end

   // Edge detect, FIFO pointers/occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_q     <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_rx_q <= fsk_bus.rx_ready;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_drop)               r_overflow <= 1'b1;
         else if (fsk_bus.clr_ovf) r_overflow <= 1'b0;
      end
   end

   // FSM state and serialiser registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_bit_cnt  <= '0;
         r_baud_cnt <= '0;
`ifdef FSK_PREAMBLE_EN
         r_pre_cnt  <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_shreg    <= w_shreg_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_baud_cnt <= w_baud_cnt_nxt;
`ifdef FSK_PREAMBLE_EN
         r_pre_cnt  <= w_pre_cnt_nxt;
`endif
      end
   end

   // Next-state logic: bit timing, word chaining and FIFO pops.
   always_comb begin
      w_state_nxt    = r_state;
      w_shreg_nxt    = r_shreg;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_baud_cnt_nxt = r_baud_cnt;
      w_pop          = 1'b0;
`ifdef FSK_PREAMBLE_EN
      w_pre_cnt_nxt  = r_pre_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_have) begin
               w_bit_cnt_nxt  = BIT_W'(DATA_W - 1);
               w_baud_cnt_nxt = '0;
`ifdef FSK_PREAMBLE_EN
               w_state_nxt    = S_PRE;
               w_shreg_nxt    = DATA_W'(PREAMBLE_WORD);
               w_pre_cnt_nxt  = PRE_W'(PREAMBLE_LEN - 1);
`else
               w_state_nxt    = S_SHIFT;
               w_shreg_nxt    = w_rd_data;
               w_pop          = 1'b1;
`endif
            end
         end
`ifdef FSK_PREAMBLE_EN
         S_PRE: begin
            if (!w_bit_end) begin
               w_baud_cnt_nxt = r_baud_cnt + 1'b1;
            end else begin
               w_baud_cnt_nxt = '0;
               if (r_bit_cnt != '0) begin
                  w_shreg_nxt   = {r_shreg[DATA_W-2:0], 1'b0};
                  w_bit_cnt_nxt = r_bit_cnt - 1'b1;
               end else if (r_pre_cnt != '0) begin
                  w_shreg_nxt   = DATA_W'(PREAMBLE_WORD);
                  w_bit_cnt_nxt = BIT_W'(DATA_W - 1);
                  w_pre_cnt_nxt = r_pre_cnt - 1'b1;
               end else if (r_level != '0) begin
                  // Burst is committed once the preamble has gone out.
                  w_state_nxt   = S_SHIFT;
                  w_shreg_nxt   = w_rd_data;
                  w_bit_cnt_nxt = BIT_W'(DATA_W - 1);
                  w_pop         = 1'b1;
               end else begin
                  w_state_nxt   = S_IDLE;
               end
            end
         end
`endif
         S_SHIFT: begin
            if (!w_bit_end) begin
               w_baud_cnt_nxt = r_baud_cnt + 1'b1;
            end else begin
               w_baud_cnt_nxt = '0;
               if (r_bit_cnt != '0) begin
                  w_shreg_nxt   = {r_shreg[DATA_W-2:0], 1'b0};
                  w_bit_cnt_nxt = r_bit_cnt - 1'b1;
               end else if (w_have) begin
                  w_shreg_nxt   = w_rd_data;
                  w_bit_cnt_nxt = BIT_W'(DATA_W - 1);
                  w_pop         = 1'b1;
               end else begin
                  w_state_nxt   = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_fsk_tx_framer.sv
// Directed/randomised bench for fsk_tx_framer with a queue-based reference model:
// accepted words are kept in order, and each burst is expected as (optional preamble
// words followed by) the queued words, MSB-first, BAUD clocks per bit, no gaps.
module tb_fsk_tx_framer;
   localparam int          DW       = 8;
   localparam int          DEPTH    = 4;
   localparam int          BAUD     = 4;
   localparam int          PRE_LEN  = 1;
   localparam logic [7:0]  PRE_WORD = 8'hAA;
`ifdef FSK_PREAMBLE_EN
   localparam int          PRE_CYC  = PRE_LEN * DW * BAUD;
`else
   localparam int          PRE_CYC  = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fsk_tx_framer_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus_if ();

   fsk_tx_framer #(
      .DATA_W(DW), .FIFO_DEPTH(DEPTH), .BAUD_DIV(BAUD),
      .PREAMBLE_LEN(PRE_LEN), .PREAMBLE_WORD(32'(PRE_WORD))
   ) dut (
      .clk(clk), .rst(rst), .fsk_bus(bus_if)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] q[$];
   logic       exp_ovf  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered and left on a negedge; the model records acceptance or a drop.
   task automatic push(input logic [7:0] d, input int hold);
      bus_if.rx_data  = d;
      bus_if.rx_ready = 1'b1;
      if (q.size() < DEPTH) q.push_back(d);
      else                  exp_ovf = 1'b1;
      repeat (hold) @(negedge clk);
      bus_if.rx_ready = 1'b0;
      bus_if.rx_data  = 8'($urandom);
      @(negedge clk);
   endtask

   task automatic fill_check(input string tag);
      chk({tag, "_level"}, 32'(bus_if.fifo_level), 32'(q.size()));
      chk({tag, "_ovf"}, 32'(bus_if.overflow), 32'(exp_ovf));
   endtask

   task automatic check_word(input logic [7:0] w);
      for (int b = DW - 1; b >= 0; b--) begin
         for (int c = 0; c < BAUD; c++) begin
            chk("fsk_bit", 32'(bus_if.fsk_bit), 32'(w[b]));
            chk("tx_active", 32'(bus_if.tx_active), 32'd1);
            chk("bit_strobe", 32'(bus_if.bit_strobe), 32'(c == 0));
            @(negedge clk);
         end
      end
   endtask

   // Called on the negedge where the first bit of a burst from IDLE should be visible.
   task automatic check_burst(input int n);
      logic [7:0] w;
`ifdef FSK_PREAMBLE_EN
      for (int p = 0; p < PRE_LEN; p++) check_word(PRE_WORD);
`endif
      for (int k = 0; k < n; k++) begin
         if (q.size() == 0) begin
            chk("model_underflow", 32'(q.size()), 32'd1);
            break;
         end
         w = q.pop_front();
         check_word(w);
      end
      chk("idle_fsk_bit", 32'(bus_if.fsk_bit), 32'd1);
      chk("idle_tx_active", 32'(bus_if.tx_active), 32'd0);
      chk("idle_strobe", 32'(bus_if.bit_strobe), 32'd0);
      chk("level_after_burst", 32'(bus_if.fifo_level), 32'(q.size()));
   endtask

   initial begin
      int n;
      bus_if.rx_ready = 1'b0;
      bus_if.rx_data  = '0;
      bus_if.enable   = 1'b0;
      bus_if.clr_ovf  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_fsk_bit", 32'(bus_if.fsk_bit), 32'd1);
      chk("rst_strobe", 32'(bus_if.bit_strobe), 32'd0);
      chk("rst_active", 32'(bus_if.tx_active), 32'd0);
      chk("rst_level", 32'(bus_if.fifo_level), 32'd0);
      chk("rst_ovf", 32'(bus_if.overflow), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single word, first bit two edges after the rx_ready rise
      bus_if.enable = 1'b1;
      push(8'hC5, 1);
      check_burst(1);

      // Two words back to back, second pushed during the first
      push(8'hFF, 1);
      fork
         push(8'h00, 1);
         check_burst(2);
      join

      // Random back-to-back bursts
      for (int r = 0; r < 2; r++) begin
         n = $urandom_range(2, 4);
         push(8'($urandom), 1);
         fork
            begin
               for (int k = 1; k < n; k++) push(8'($urandom), 1);
            end
            check_burst(n);
         join
      end

      // Fill with enable low, overflow on the fifth word, drop beats clear
      bus_if.enable = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         push(8'(8'hA0 + k), $urandom_range(1, 3));
         fill_check("fill");
      end
      bus_if.clr_ovf  = 1'b1;
      bus_if.rx_data  = 8'hA6;
      bus_if.rx_ready = 1'b1;
      @(negedge clk);
      bus_if.clr_ovf  = 1'b0;
      bus_if.rx_ready = 1'b0;
      chk("drop_beats_clr", 32'(bus_if.overflow), 32'd1);
      @(negedge clk);
      bus_if.clr_ovf = 1'b1;
      @(negedge clk);
      bus_if.clr_ovf = 1'b0;
      exp_ovf = 1'b0;
      fill_check("clr");
      bus_if.enable = 1'b1;
      @(negedge clk);
      check_burst(4);
      bus_if.enable = 1'b0;

      // Random fill / drain rounds
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            push(8'($urandom), $urandom_range(1, 4));
            fill_check("rfill");
         end
         if (exp_ovf) begin
            bus_if.clr_ovf = 1'b1;
            @(negedge clk);
            bus_if.clr_ovf = 1'b0;
            exp_ovf = 1'b0;
            fill_check("rclr");
         end
         bus_if.enable = 1'b1;
         @(negedge clk);
         check_burst(q.size());
         bus_if.enable = 1'b0;
      end

      // Long rx_ready pulse pushes once
      push(8'h3C, 10);
      fill_check("long_pulse");
      bus_if.enable = 1'b1;
      @(negedge clk);
      check_burst(1);
      bus_if.enable = 1'b0;

      // enable falls mid-word: word completes, FIFO keeps the rest
      push(8'($urandom), 1);
      push(8'($urandom), 1);
      bus_if.enable = 1'b1;
      @(negedge clk);
      fork
         begin
            repeat (PRE_CYC + 10) @(negedge clk);
            bus_if.enable = 1'b0;
         end
         check_burst(1);
      join
      repeat (10) @(negedge clk);
      chk("held_active", 32'(bus_if.tx_active), 32'd0);
      chk("held_level", 32'(bus_if.fifo_level), 32'd1);
      bus_if.enable = 1'b1;
      @(negedge clk);
      check_burst(1);

      // Reset in the middle of bit 3 aborts everything
      bus_if.enable = 1'b0;
      for (int k = 0; k < 3; k++) push(8'($urandom), 1);
      bus_if.enable = 1'b1;
      @(negedge clk);
      repeat (PRE_CYC + 3 * BAUD + 1) @(negedge clk);
      chk("pre_rst_level", 32'(bus_if.fifo_level), 32'd2);
      chk("pre_rst_active", 32'(bus_if.tx_active), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_fsk_bit", 32'(bus_if.fsk_bit), 32'd1);
      chk("abort_active", 32'(bus_if.tx_active), 32'd0);
      chk("abort_level", 32'(bus_if.fifo_level), 32'd0);
      q.delete();
      exp_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         chk("post_rst_active", 32'(bus_if.tx_active), 32'd0);
         chk("post_rst_fsk_bit", 32'(bus_if.fsk_bit), 32'd1);
      end
      fill_check("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
